// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one registered output channel among four requesters a..d.
// Latency: req to out_valid is one cycle when the output register is free; gnt pulses for one cycle per capture.
// Backpressure: y/sel hold while out_valid & ~out_ready. Optional RR_MUX_ARBITER_GNT_COUNT_EN adds xfer_count.
module rr_mux_arbiter #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] c,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  out_valid,
    output logic [1:0]            sel,
    output logic [3:0]            gnt
`ifdef RR_MUX_ARBITER_GNT_COUNT_EN
    ,
    output logic [15:0]           xfer_count
`endif
);

    logic [DATA_WIDTH-1:0] y_q, y_d;
    logic                  valid_q, valid_d;
    logic [1:0]            sel_q, sel_d;
    logic [3:0]            gnt_q, gnt_d;
    logic [1:0]            last_q, last_d;

    logic [3:0]            elig;
    logic                  win_found;
    logic [1:0]            win_idx;
    logic [1:0]            cand;
    logic [DATA_WIDTH-1:0] win_dat;
    logic                  load;
    logic                  accept;

    // Last cycle's grantee is masked so a stale req cannot win twice.
    assign elig   = req & ~gnt_q;
    assign accept = valid_q & out_ready;

    // Scan from the farthest offset down so the nearest eligible index after last wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = last_q;
        for (int k = 4; k >= 1; k--) begin
            cand = last_q + k[1:0];
            if (elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_dat = a;
        case (win_idx)
            2'd0:    win_dat = a;
            2'd1:    win_dat = b;
            2'd2:    win_dat = c;
            default: win_dat = d;
        endcase
    end

    assign load = (~valid_q | out_ready) & win_found;

    always_comb begin
        y_d     = y_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        last_d  = last_q;
        gnt_d   = 4'b0000;
        if (load) begin
            y_d     = win_dat;
            sel_d   = win_idx;
            valid_d = 1'b1;
            gnt_d   = 4'b0001 << win_idx;
            last_d  = win_idx;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            valid_q <= 1'b0;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            last_q  <= 2'd3;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    assign y         = y_q;
    assign out_valid = valid_q;
    assign sel       = sel_q;
    assign gnt       = gnt_q;

`ifdef RR_MUX_ARBITER_GNT_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of completed handshakes.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_count = cnt_q;
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: reference model compared every cycle plus directed literal checks.
module tb_rr_mux_arbiter;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [DW-1:0] a, b, c, d;
    logic          out_ready;
    logic [DW-1:0] y;
    logic          out_valid;
    logic [1:0]    sel;
    logic [3:0]    gnt;
`ifdef RR_MUX_ARBITER_GNT_COUNT_EN
    logic [15:0]   xfer_count;
`endif

    rr_mux_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_ready (out_ready),
        .y         (y),
        .out_valid (out_valid),
        .sel       (sel),
        .gnt       (gnt)
`ifdef RR_MUX_ARBITER_GNT_COUNT_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: priority rotates from the last winner; the previous grantee sits out one cycle.
    bit          m_init = 1'b0;
    int          m_last, m_sel, m_gidx, m_xfer;
    bit          m_vld;
    logic [3:0]  m_y;

    function automatic logic [3:0] src(input int i);
        case (i)
            0:       return a;
            1:       return b;
            2:       return c;
            default: return d;
        endcase
    endfunction

    always @(posedge clk) begin
        int  w;
        int  i;
        bit  acc;
        if (rst) begin
            m_init <= 1'b1;
            m_last <= 3;
            m_vld  <= 1'b0;
            m_y    <= 4'd0;
            m_sel  <= 0;
            m_gidx <= -1;
            m_xfer <= 0;
        end else if (m_init) begin
            w   = -1;
            acc = m_vld && out_ready;
            for (int k = 1; k <= 4; k++) begin
                i = (m_last + k) % 4;
                if (w < 0 && req[i] && i != m_gidx) w = i;
            end
            if (acc && m_xfer < 65535) m_xfer <= m_xfer + 1;
            if (w >= 0 && (!m_vld || out_ready)) begin
                m_y    <= src(w);
                m_sel  <= w;
                m_vld  <= 1'b1;
                m_gidx <= w;
                m_last <= w;
            end else begin
                m_gidx <= -1;
                if (acc) m_vld <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] eg;
        if (m_init) begin
            eg = (m_gidx < 0) ? 32'd0 : (32'd1 << m_gidx);
            check("model_y",         32'(y),         32'(m_y));
            check("model_out_valid", 32'(out_valid), 32'(m_vld));
            check("model_sel",       32'(sel),       32'(m_sel));
            check("model_gnt",       32'(gnt),       eg);
`ifdef RR_MUX_ARBITER_GNT_COUNT_EN
            check("model_xfer_count", 32'(xfer_count), 32'(m_xfer));
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [1:0] rr_sel [5];
    logic [3:0] rr_gnt [5];
    logic [3:0] rr_y   [5];

    initial begin
        rr_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_y   = '{4'b0110, 4'b1010, 4'b1001, 4'b0101, 4'b0110};

        rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
        a = 4'b0110; b = 4'b1010; c = 4'b1001; d = 4'b0101;

        // Reset then idle
        repeat (2) cyc();
        rst = 1'b0;
        check("reset_y",   32'(y),         32'd0);
        check("reset_vld", 32'(out_valid), 32'd0);
        check("reset_gnt", 32'(gnt),       32'd0);
        check("reset_sel", 32'(sel),       32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("idle_vld", 32'(out_valid), 32'd0);
            check("idle_gnt", 32'(gnt),       32'd0);
            check("idle_y",   32'(y),         32'd0);
        end

        // Single grant, source drops req on seeing gnt
        req = 4'b0001; out_ready = 1'b1;
        cyc();
        check("single_y",   32'(y),         32'b0110);
        check("single_sel", 32'(sel),       32'd0);
        check("single_vld", 32'(out_valid), 32'd1);
        check("single_gnt", 32'(gnt),       32'b0001);
        req = 4'b0000;
        cyc();
        check("single_vld_drop", 32'(out_valid), 32'd0);
        check("single_gnt_drop", 32'(gnt),       32'd0);

        // Round robin from a fresh reset
        rst = 1'b1;
        cyc();
        rst = 1'b0; req = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("rr_sel", 32'(sel), 32'(rr_sel[i]));
            check("rr_gnt", 32'(gnt), 32'(rr_gnt[i]));
            check("rr_y",   32'(y),   32'(rr_y[i]));
        end
        req = 4'b0000;
        cyc();
        check("rr_drain_vld", 32'(out_valid), 32'd0);

        // Backpressure: b captured and held, then c once ready returns
        req = 4'b0110; out_ready = 1'b0;
        cyc();
        check("bp_y",   32'(y),   32'b1010);
        check("bp_sel", 32'(sel), 32'd1);
        check("bp_gnt", 32'(gnt), 32'b0010);
        req = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("bp_hold_y",   32'(y),         32'b1010);
            check("bp_hold_sel", 32'(sel),       32'd1);
            check("bp_hold_gnt", 32'(gnt),       32'd0);
            check("bp_hold_vld", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        cyc();
        check("bp_next_y",   32'(y),   32'b1001);
        check("bp_next_sel", 32'(sel), 32'd2);
        check("bp_next_gnt", 32'(gnt), 32'b0100);
        req = 4'b0000;
        cyc();
        check("bp_drain_vld", 32'(out_valid), 32'd0);

        // Single requester: mask gives one item every other cycle
        req = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("mask_vld", 32'(out_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("mask_gnt", 32'(gnt),       (i % 2 == 0) ? 32'b1000 : 32'd0);
        end

        // Reset while holding an unaccepted item
        out_ready = 1'b0;
        cyc();
        check("rstmid_pre_vld", 32'(out_valid), 32'd1);
        check("rstmid_pre_y",   32'(y),         32'b0101);
        rst = 1'b1;
        cyc();
        check("rstmid_vld", 32'(out_valid), 32'd0);
        check("rstmid_gnt", 32'(gnt),       32'd0);
        check("rstmid_y",   32'(y),         32'd0);
        rst = 1'b0; req = 4'b1111; out_ready = 1'b1;
        cyc();
        check("rstmid_first_sel", 32'(sel), 32'd0);
        check("rstmid_first_gnt", 32'(gnt), 32'b0001);

`ifdef RR_MUX_ARBITER_GNT_COUNT_EN
        rst = 1'b1;
        cyc();
        check("count_reset", 32'(xfer_count), 32'd0);
        rst = 1'b0; req = 4'b1111; out_ready = 1'b1;
        repeat (11) cyc();
        check("count_ten", 32'(xfer_count), 32'd10);
`endif

        req = 4'b0000;
        repeat (3) cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
